timer_bank: RTL and testbench
=============================

Name: timer_bank

Overview:
- Multi-channel programmable tick generator; the parametrised successor of the single fixed-threshold counter.
- One shared clock prescaler drives NCH independent channels.
- Each channel has a runtime-loadable period, periodic or one-shot mode, and start/stop control.
- Supplies periodic strobes (UART baud, refresh, watchdog, scheduler ticks) to the rest of the CPU system.

Parameters:
- NCH, 4, number of channels (1..16)
- WIDTH, 16, bits per channel period/count register
- PRESCALE_W, 8, bits of the shared prescaler

Ports:
- i_clk  in  1  clock; all logic rising-edge.
- i_rst  in  1  synchronous, active-low reset.
- i_en  in  1  global enable; when 0 the prescaler and all channels freeze (state held, no ticks).
- i_prescale  in  PRESCALE_W  prescaler terminal value; strobe every i_prescale+1 clocks.
- i_wr  in  1  load the period/mode of channel i_wr_ch.
- i_wr_ch  in  $clog2(NCH) (min 1)  channel select for i_wr.
- i_wr_period  in  WIDTH  period value P; channel ticks every P+1 strobes.
- i_wr_mode  in  1  0 = periodic, 1 = one-shot.
- i_start  in  NCH  per-channel start/restart pulse.
- i_stop  in  NCH  per-channel stop pulse.
- o_tick  out  NCH  one-clock tick pulse per channel, registered.
- o_busy  out  NCH  channel is in RUN.
- o_count  out  NCH*WIDTH  live count per channel; channel k occupies bits [k*WIDTH +: WIDTH].

Behaviour:
- Reset (i_rst==0 at an edge): prescaler=0, every count=0, period=0, mode=periodic, state=IDLE, o_tick=0, o_busy=0. Reset has priority over all other inputs, including mid-count.
- Prescaler: counts only when i_en=1.
  - strobe = i_en && (pre >= i_prescale); on strobe pre<=0, else pre<=pre+1.
  - i_prescale=0 gives a strobe every enabled cycle.
  - The >= rule covers i_prescale being lowered below the current pre.
- Channel FSM has two states, IDLE and RUN.
  - IDLE -> RUN on i_start[k]; count<=0.
  - RUN + i_start[k]: restart, count<=0, no tick that cycle.
  - RUN + i_stop[k]: go to IDLE; count holds its value. Stop beats start when both are asserted.
  - RUN + strobe, count >= period: o_tick[k]<=1 and count<=0. Periodic mode stays in RUN; one-shot mode goes to IDLE.
  - RUN + strobe, count < period: count<=count+1.
  - In every case not listed above, o_tick[k]<=0.
- Timing: with i_prescale=0 and P written, start at edge N gives the first tick high during the cycle after edge N+P+1. The tick interval is (P+1)*(i_prescale+1) clocks. P=0 ticks on every strobe.
- Write rules:
  - i_wr updates period/mode of i_wr_ch at the edge and takes effect immediately, even while in RUN.
  - If the new period is less than the current count, the next strobe ticks and wraps (the >= rule).
  - i_wr with i_wr_ch >= NCH is ignored.
- Simultaneous events:
  - i_wr and a start to the same channel in one cycle: both apply; the run uses the new period.
  - Tick and start in the same cycle: start wins, no tick.
- Count never exceeds the period except transiently after a write; no overflow at 2^WIDTH-1 because the compare catches it first.

Optional Feature:
- Macro: TIMER_BANK_IRQ_EN.
- Defined: adds input i_irq_clr[NCH] and outputs o_irq_pend[NCH] and o_irq.
  - o_irq_pend[k] sets on o_tick[k] and clears on i_irq_clr[k]. Set beats clear in the same cycle.
  - o_irq is the OR of all pending bits, registered.
  - All three reset to 0.
- Undefined: those ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package timer_pkg holds:
  - the mode encoding (MODE_PERIODIC=0, MODE_ONESHOT=1)
  - the FSM state encoding (ST_IDLE, ST_RUN)
  - default widths
- Sub-module timer_channel: one FSM, count and period register per channel.
  - Inputs: strobe, start, stop, and a write strobe already decoded per channel.
  - Outputs: tick, busy, count.
  - Instantiated NCH times with a generate loop.
  - The prescaler, write decode and IRQ logic live in timer_bank.

Test Plan:
- Reset mid-run: ch0 P=5 running at count 3, i_rst=0 for one edge -> count 0, o_busy=0, o_tick=0, then IDLE until the next start.
- Basic period: i_prescale=0, ch0 P=3 periodic, start at cycle 10 -> o_tick[0] high in cycles 15, 19, 23, exactly one clock wide.
- Prescale plus one-shot: i_prescale=2, ch1 P=1 one-shot, start -> a single tick 6 clocks after the start edge, then o_busy[1]=0 and no further ticks.
- Freeze and boundaries:
  - i_en low for 7 cycles mid-count -> tick is delayed by exactly 7 cycles.
  - P=0 -> tick on every strobe.
  - P=16'hFFFF -> tick after 65536 strobes, count wraps to 0.
- Live rewrite: ch2 P=10 at count 8, write P=4 -> tick on the next strobe, then every 5 strobes. Simultaneous start+stop -> IDLE. Write to ch index 5 with NCH=4 -> no effect.
- IRQ (TIMER_BANK_IRQ_EN): ticks on ch0 and ch3 -> o_irq_pend=4'b1001, o_irq=1. Clear ch0 -> 4'b1000. Clear and tick on the same cycle -> bit stays set.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared encodings and default sizes for the timer bank and its channels.
package timer_pkg;

  localparam int unsigned NCH_DEF        = 4;
  localparam int unsigned WIDTH_DEF      = 16;
  localparam int unsigned PRESCALE_W_DEF = 8;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN FSM with a loadable period, periodic or one-shot.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_strobe,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_period,
  input  logic             i_wr_mode,
  output logic             o_tick,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_count
);

  state_e           state_q, state_d;
  mode_e            mode_q;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] count_d;
  logic             tick_d;

  // State, count and tick registers; period/mode load independently of the FSM.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      o_count  <= '0;
      o_tick   <= 1'b0;
      period_q <= '0;
      mode_q   <= MODE_PERIODIC;
    end else begin
      state_q <= state_d;
      o_count <= count_d;
      o_tick  <= tick_d;
      if (i_wr) begin
        period_q <= i_wr_period;
        mode_q   <= mode_e'(i_wr_mode);
      end
    end
  end

  // Stop outranks start, start outranks a terminal-count tick.
  always_comb begin
    state_d = state_q;
    count_d = o_count;
    tick_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          state_d = ST_IDLE;
        end else if (i_start) begin
          count_d = '0;
        end else if (i_strobe) begin
          if (o_count >= period_q) begin
            tick_d  = 1'b1;
            count_d = '0;
            if (mode_q == MODE_ONESHOT) state_d = ST_IDLE;
          end else begin
            count_d = o_count + WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy = (state_q == ST_RUN);

endmodule

// File: rtl/timer_bank.sv
// Multi-channel tick generator: shared prescaler feeding NCH timer_channel instances.
// Optional interrupt pending/summary logic is built when TIMER_BANK_IRQ_EN is defined.
module timer_bank
  import timer_pkg::*;
#(
  parameter  int unsigned NCH        = NCH_DEF,
  parameter  int unsigned WIDTH      = WIDTH_DEF,
  parameter  int unsigned PRESCALE_W = PRESCALE_W_DEF,
  localparam int unsigned CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_wr,
  input  logic [CH_W-1:0]       i_wr_ch,
  input  logic [WIDTH-1:0]      i_wr_period,
  input  logic                  i_wr_mode,
  input  logic [NCH-1:0]        i_start,
  input  logic [NCH-1:0]        i_stop,
  output logic [NCH-1:0]        o_tick,
  output logic [NCH-1:0]        o_busy,
`ifdef TIMER_BANK_IRQ_EN
  input  logic [NCH-1:0]        i_irq_clr,
  output logic [NCH-1:0]        o_irq_pend,
  output logic                  o_irq,
`endif
  output logic [NCH*WIDTH-1:0]  o_count
);

  logic [PRESCALE_W-1:0] pre_q;
  logic                  strobe;
  logic [NCH-1:0]        start_g;
  logic [NCH-1:0]        stop_g;

  // >= compare lets a lowered prescale value take effect without a long wrap.
  assign strobe  = i_en && (pre_q >= i_prescale);
  assign start_g = i_start & {NCH{i_en}};
  assign stop_g  = i_stop & {NCH{i_en}};

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      pre_q <= '0;
    end else if (i_en) begin
      pre_q <= strobe ? '0 : pre_q + PRESCALE_W'(1);
    end
  end

  // Out-of-range channel selects match no instance and are dropped.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_strobe    (strobe),
      .i_start     (start_g[k]),
      .i_stop      (stop_g[k]),
      .i_wr        (i_wr && (i_wr_ch == CH_W'(k))),
      .i_wr_period (i_wr_period),
      .i_wr_mode   (i_wr_mode),
      .o_tick      (o_tick[k]),
      .o_busy      (o_busy[k]),
      .o_count     (o_count[k*WIDTH +: WIDTH])
    );
  end

`ifdef TIMER_BANK_IRQ_EN
  // A tick sets its pending bit even when cleared in the same cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_irq_pend <= '0;
      o_irq      <= 1'b0;
    end else begin
      o_irq_pend <= (o_irq_pend & ~i_irq_clr) | o_tick;
      o_irq      <= |o_irq_pend;
    end
  end
`endif

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: expected tick cycles are queued when stimulus is driven
// and popped by a tick monitor; state checks are immediate assertions in the driver.
module tb_timer_bank;

  localparam int unsigned NCH  = 5;
  localparam int unsigned W    = 16;
  localparam int unsigned PW   = 8;
  localparam int unsigned CH_W = 3;

  logic              clk = 1'b0;
  logic              i_rst = 1'b0;
  logic              i_en = 1'b1;
  logic [PW-1:0]     i_prescale = '0;
  logic              i_wr = 1'b0;
  logic [CH_W-1:0]   i_wr_ch = '0;
  logic [W-1:0]      i_wr_period = '0;
  logic              i_wr_mode = 1'b0;
  logic [NCH-1:0]    i_start = '0;
  logic [NCH-1:0]    i_stop = '0;
  logic [NCH-1:0]    o_tick;
  logic [NCH-1:0]    o_busy;
  logic [NCH*W-1:0]  o_count;
`ifdef TIMER_BANK_IRQ_EN
  logic [NCH-1:0]    i_irq_clr = '0;
  logic [NCH-1:0]    o_irq_pend;
  logic              o_irq;
`endif

  typedef struct {
    int ch;
    int cyc;
  } tick_t;

  tick_t sb[$];
  tick_t mon_e;
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    n;

  timer_bank #(.NCH(NCH), .WIDTH(W), .PRESCALE_W(PW)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_prescale  (i_prescale),
    .i_wr        (i_wr),
    .i_wr_ch     (i_wr_ch),
    .i_wr_period (i_wr_period),
    .i_wr_mode   (i_wr_mode),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .o_tick      (o_tick),
    .o_busy      (o_busy),
`ifdef TIMER_BANK_IRQ_EN
    .i_irq_clr   (i_irq_clr),
    .o_irq_pend  (o_irq_pend),
    .o_irq       (o_irq),
`endif
    .o_count     (o_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [NCH-1:0] sta, input logic [NCH-1:0] sto);
    i_start = sta;
    i_stop  = sto;
    step(1);
    i_start = '0;
    i_stop  = '0;
  endtask

  task automatic wr(input int ch, input int p, input logic m);
    i_wr        = 1'b1;
    i_wr_ch     = CH_W'(ch);
    i_wr_period = W'(p);
    i_wr_mode   = m;
    step(1);
    i_wr = 1'b0;
  endtask

  task automatic expect_tick(input int ch, input int at);
    tick_t e;
    e.ch  = ch;
    e.cyc = at;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] cnt(input int k);
    return 32'(o_count[k*W +: W]);
  endfunction

  // Every observed tick must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (o_tick[k]) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL tick_unexpected ch=%0d cyc=%0d expected no tick", k, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("tick_ch", 32'(k), 32'(mon_e.ch));
          chk("tick_cyc", 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end
  end

  initial begin
    step(3);
    i_rst = 1'b1;
    chk("rst_tick", 32'(o_tick), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_count_lo", o_count[31:0], 32'h0);

    // Basic period with write and start in the same cycle.
    i_wr = 1'b1; i_wr_ch = 3'd0; i_wr_period = 16'd3; i_wr_mode = 1'b0;
    pulse(5'b00001, 5'b00000);
    i_wr = 1'b0;
    n = cyc;
    expect_tick(0, n + 4); expect_tick(0, n + 8); expect_tick(0, n + 12);
    step(12);
    chk("basic_busy", 32'(o_busy[0]), 32'h1);
    pulse(5'b00000, 5'b00001);
    chk("basic_stop_busy", 32'(o_busy[0]), 32'h0);

    // Reset mid-run, then period back to 0.
    wr(0, 5, 1'b0);
    pulse(5'b00001, 5'b00000);
    step(3);
    chk("midrun_count", cnt(0), 32'd3);
    i_rst = 1'b0;
    step(1);
    i_rst = 1'b1;
    chk("midrst_count", cnt(0), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'h0);
    chk("midrst_tick", 32'(o_tick), 32'h0);
    step(5);
    chk("midrst_idle", 32'(o_busy[0]), 32'h0);
    pulse(5'b00001, 5'b00000);
    n = cyc;
    expect_tick(0, n + 1); expect_tick(0, n + 2);
    step(2);
    pulse(5'b00000, 5'b00001);

    // Prescale 2, one-shot P=1; prescaler phase is 0 when the start is driven.
    wr(1, 1, 1'b1);
    i_prescale = 8'd2;
    pulse(5'b00010, 5'b00000);
    n = cyc;
    expect_tick(1, n + 5);
    step(8);
    chk("oneshot_busy", 32'(o_busy[1]), 32'h0);
    chk("oneshot_count", cnt(1), 32'd0);
    step(10);
    i_prescale = 8'd0;
    step(1);

    // Freeze for 7 cycles mid-count.
    wr(0, 5, 1'b0);
    pulse(5'b00001, 5'b00000);
    n = cyc;
    expect_tick(0, n + 13);
    step(1);
    i_en = 1'b0;
    step(7);
    chk("freeze_count", cnt(0), 32'd1);
    i_en = 1'b1;
    step(5);
    pulse(5'b00000, 5'b00001);
    chk("freeze_stop_busy", 32'(o_busy[0]), 32'h0);

    // P=0 ticks on every strobe.
    wr(1, 0, 1'b0);
    pulse(5'b00010, 5'b00000);
    n = cyc;
    for (int i = 1; i <= 4; i++) expect_tick(1, n + i);
    step(4);
    pulse(5'b00000, 5'b00010);

    // Live rewrite below the current count.
    wr(2, 10, 1'b0);
    pulse(5'b00100, 5'b00000);
    n = cyc;
    step(8);
    chk("rewrite_count8", cnt(2), 32'd8);
    wr(2, 4, 1'b0);
    chk("rewrite_count9", cnt(2), 32'd9);
    expect_tick(2, n + 10); expect_tick(2, n + 15); expect_tick(2, n + 20);
    step(11);
    pulse(5'b00000, 5'b00100);

    // Start and stop together in RUN: stop wins, count holds.
    wr(3, 20, 1'b0);
    pulse(5'b01000, 5'b00000);
    step(6);
    pulse(5'b01000, 5'b01000);
    chk("startstop_busy", 32'(o_busy[3]), 32'h0);
    chk("startstop_count", cnt(3), 32'd6);
    step(3);
    chk("startstop_hold", cnt(3), 32'd6);

    // Writes to channel indices 5 and 7 must not touch any channel.
    wr(5, 2, 1'b1);
    wr(7, 2, 1'b1);
    pulse(5'b00010, 5'b00000);
    n = cyc;
    expect_tick(1, n + 1); expect_tick(1, n + 2);
    step(2);
    chk("oor_ch1_busy", 32'(o_busy[1]), 32'h1);
    pulse(5'b00000, 5'b00010);
    pulse(5'b01000, 5'b00000);
    n = cyc;
    expect_tick(3, n + 21);
    step(21);
    chk("oor_ch3_busy", 32'(o_busy[3]), 32'h1);
    pulse(5'b00000, 5'b01000);

    // Full-range period.
    wr(0, 16'hFFFF, 1'b0);
    pulse(5'b00001, 5'b00000);
    n = cyc;
    expect_tick(0, n + 65536);
    step(65535);
    chk("max_count", cnt(0), 32'h0000FFFF);
    step(1);
    chk("max_wrap", cnt(0), 32'd0);
    chk("max_tick", 32'(o_tick[0]), 32'h1);
    pulse(5'b00000, 5'b00001);

`ifdef TIMER_BANK_IRQ_EN
    i_irq_clr = '1;
    step(1);
    i_irq_clr = '0;
    step(1);
    chk("irq_pre_pend", 32'(o_irq_pend), 32'h0);
    chk("irq_pre_irq", 32'(o_irq), 32'h0);
    wr(0, 2, 1'b0);
    wr(3, 2, 1'b0);
    pulse(5'b01001, 5'b00000);
    n = cyc;
    expect_tick(0, n + 3); expect_tick(3, n + 3);
    step(3);
    pulse(5'b00000, 5'b01001);
    chk("irq_pend", 32'(o_irq_pend), 32'h09);
    step(1);
    chk("irq_out", 32'(o_irq), 32'h1);
    i_irq_clr = 5'b00001;
    step(1);
    i_irq_clr = '0;
    chk("irq_clr0", 32'(o_irq_pend), 32'h08);
    pulse(5'b01000, 5'b00000);
    n = cyc;
    expect_tick(3, n + 3);
    step(3);
    i_irq_clr = 5'b01000;
    pulse(5'b00000, 5'b01000);
    i_irq_clr = '0;
    chk("irq_set_beats_clr", 32'(o_irq_pend), 32'h08);
    i_irq_clr = 5'b01000;
    step(1);
    i_irq_clr = '0;
    step(1);
    chk("irq_final_pend", 32'(o_irq_pend), 32'h0);
    chk("irq_final_irq", 32'(o_irq), 32'h0);
`endif

    step(5);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
